// File: rtl/add_accumulator_pkg.sv
// Shared types and default sizes for the add_accumulator block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package add_accumulator_pkg;

  // Default operand/sum width and operand-count field width.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : add_accumulator_pkg

// File: rtl/add_accumulator_adder32.sv
// Unsigned WIDTH-bit adder with carry-out; the single adder of the accumulator.
// Latency: purely combinational.
// Backpressure: none.
module Adder32Bit #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  // Zero-extend both operands so the top bit of the result is the carry-out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule : Adder32Bit

// File: rtl/add_accumulator.sv
// Sums len unsigned operands from a valid/ready stream; ADD_ACCUMULATOR_SAT_EN selects saturation.
// Latency: result valid 1 cycle after the last operand is accepted (len=0: 1 cycle after start).
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
module add_accumulator
  import add_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  input  logic             out_ready,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               carry_q, carry_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               accept;

  // The one adder in the datapath: running sum plus the incoming operand.
  Adder32Bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .sum  (add_sum),
    .cout (add_cout),
    .a    (acc_q),
    .b    (in_data)
  );

  // Handshake and status decode straight from the state register, so no
  // input-to-output combinational path exists.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_carry = carry_q;
  assign accept    = in_valid && (state_q == ACCUM);

  // Next-state and datapath update; every target defaults to holding.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          carry_d = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          carry_d = carry_q | add_cout;
`ifdef ADD_ACCUMULATOR_SAT_EN
          // Once any addition has overflowed the sum is pinned at all-ones.
          acc_d = (add_cout || carry_q) ? {WIDTH{1'b1}} : add_sum;
`else
          acc_d = add_sum;
`endif
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // start is deliberately not looked at here, even on the handshake cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
    end
  end

endmodule : add_accumulator

// File: tb/tb_add_accumulator.sv
// Scoreboard bench for add_accumulator: stimulus pushes expected results, monitor pops on handshake.
// Latency: checks result appears 1 cycle after last accept / after a len=0 start.
// Backpressure: exercises out_ready held low and gapped in_valid.
module tb_add_accumulator;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;
  localparam int TMO   = 100;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  logic [WIDTH:0] exp_q[$];   // {carry, sum}

  add_accumulator #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts accepted operands and scores each result handshake.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) accepts++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(out_sum), 64'hDEAD);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("out_sum", 64'(out_sum), 64'(e[WIDTH-1:0]));
        check("out_carry", 64'(out_carry), 64'(e[WIDTH]));
      end
    end
  end

  task automatic do_start(input logic [CNT_W-1:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0;
    rst_n = 1'b0; start = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    // Reset state.
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_sum", 64'(out_sum), 64'(0));
    check("rst_out_carry", 64'(out_carry), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // 0x8 + 0x9.
    a0 = accepts;
    exp_q.push_back({1'b0, 32'h11});
    do_start(8'd2);
    send(32'h8);
    send(32'h9);
    wait_idle();
    check("t1_accepts", 64'(accepts - a0), 64'(2));

    // 0xB + 0x1 + 0xF with one idle cycle between operands.
    a0 = accepts;
    exp_q.push_back({1'b0, 32'h1B});
    do_start(8'd3);
    send(32'hB);
    idle_cycles(1);
    send(32'h1);
    idle_cycles(1);
    send(32'hF);
    idle_cycles(2);
    wait_idle();
    check("t2_accepts", 64'(accepts - a0), 64'(3));

    // Overflow: carry sticky, wrap or saturate.
`ifdef ADD_ACCUMULATOR_SAT_EN
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
`else
    exp_q.push_back({1'b1, 32'h0000_0001});
`endif
    do_start(8'd2);
    send(32'hFFFF_FFFF);
    send(32'h2);
    wait_idle();

    // len=0: result the cycle after start, held under backpressure.
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0});
    do_start(8'd0);
    @(negedge clk);
    check("t4_valid_next_cycle", 64'(out_valid), 64'(1));
    check("t4_in_ready_done", 64'(in_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(out_valid), 64'(1));
      check("t4_hold_sum", 64'(out_sum), 64'(0));
      check("t4_hold_carry", 64'(out_carry), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();
    check("t4_busy_after", 64'(busy), 64'(0));

    // Reset mid-accumulation discards the partial sum.
    do_start(8'd4);
    send(32'h1);
    send(32'h2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_in_ready", 64'(in_ready), 64'(0));
    check("t5_rst_sum", 64'(out_sum), 64'(0));
    check("t5_rst_carry", 64'(out_carry), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(4);
    check("t5_no_result", 64'(out_valid), 64'(0));
    exp_q.push_back({1'b0, 32'h5});
    do_start(8'd1);
    send(32'h5);
    wait_idle();

    // start ignored in ACCUM and on the DONE handshake cycle.
    exp_q.push_back({1'b0, 32'h30});
    do_start(8'd2);
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    send(32'h10);
    send(32'h20);
    wait_valid();
    @(posedge clk); #1;
    start = 1'b1; len = 8'd1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t6_idle_after_hs", 64'(busy), 64'(0));
    idle_cycles(3);
    check("t6_still_idle", 64'(busy), 64'(0));

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_add_accumulator

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and sum width.
REQ-002 SHALL have parameter CNT_W, default 8, width of operand-count field.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, begin a new accumulation (sampled in IDLE only).
REQ-006 SHALL have port len, input, CNT_W, number of operands to sum, captured with start.
REQ-007 SHALL have ports in_valid input 1, in_data input WIDTH, in_ready output 1: operand stream.
REQ-008 SHALL have ports out_valid output 1, out_sum output WIDTH, out_carry output 1, out_ready input 1: result.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-011 IDLE: on start=1 SHALL capture len, clear acc and carry to 0, go to ACCUM; if len=0, go directly to DONE with out_sum=0, out_carry=0.
REQ-012 ACCUM: in_ready SHALL be 1; operand accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-013 On acceptance SHALL set acc <= acc + in_data (WIDTH-bit) and remaining <= remaining - 1; one operand per cycle maximum.
REQ-014 out_carry SHALL be sticky: set if any accepted addition produces carry-out of bit WIDTH-1.
REQ-015 When the operand that brings remaining to 0 is accepted, SHALL enter DONE next cycle; out_valid=1 in the first DONE cycle (latency 1 cycle from last accept).
REQ-016 DONE: out_valid, out_sum, out_carry SHALL hold stable until out_ready=1; on out_valid&out_ready return to IDLE next cycle.
REQ-017 in_ready SHALL be 0 in IDLE and DONE; in_valid outside ACCUM SHALL be ignored.
REQ-018 start outside IDLE SHALL be ignored, including start in the same cycle as the DONE handshake.
REQ-019 out_sum SHALL equal the accumulator register directly (no combinational path from in_data to outputs).
REQ-020 in_valid dropping mid-stream SHALL stall ACCUM with acc and remaining unchanged, no timeout.
REQ-021 Arithmetic SHALL be unsigned; len max 2^CNT_W-1 operands.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, acc=0, remaining=0, out_carry=0, out_valid=0, in_ready=0, busy=0, regardless of state.
REQ-023 Reset mid-accumulation SHALL discard partial sum; no result emitted afterwards until a new start.

Configuration
REQ-024 Macro ADD_ACCUMULATOR_SAT_EN SHALL select overflow handling.
REQ-025 Defined: on any carry-out acc SHALL saturate to all-ones and remain all-ones for the rest of the run; out_carry still set.
REQ-026 Undefined: acc SHALL wrap modulo 2^WIDTH; out_carry set as per REQ-014.

Structure
REQ-027 Shared package SHALL hold FSM state enum (IDLE, ACCUM, DONE) and default WIDTH/CNT_W constants.
REQ-028 Addition SHALL be done by one instance of the existing Adder32Bit sub-module (ports sum, carry-out, a, b; a=acc, b=in_data); no second adder.

Verification
REQ-029 len=2, operands 0x8,0x9 -> out_valid with out_sum=0x11, out_carry=0.
REQ-030 len=3, operands 0xB,0x1,0xF, in_valid gapped 1 cycle between each -> out_sum=0x1B, out_carry=0, no extra accepts.
REQ-031 len=2, operands 0xFFFFFFFF,0x2 -> out_carry=1; out_sum=0x1 without macro, 0xFFFFFFFF with ADD_ACCUMULATOR_SAT_EN.
REQ-032 len=0, start -> out_valid next cycle with out_sum=0; out_ready held 0 for 5 cycles -> outputs stable, then handshake -> IDLE.
REQ-033 len=4, rst_n pulsed low after 2 accepts -> all outputs 0 immediately; new start len=1 operand 0x5 -> out_sum=0x5.
REQ-034 start asserted during ACCUM and during DONE handshake cycle -> ignored; len not recaptured.
